// File: rtl/tmds_frame_gate.sv
// Channel-0 TMDS timing extractor: recovers pixel-valid/hsync/vsync from control
// tokens and guard bands, decimates frames, delays strobes, and measures frame size.
module tmds_frame_gate #(
  parameter int unsigned DELAY   = 9,
  parameter int unsigned DECIM_W = 4,
  parameter int unsigned CNT_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [9:0]         ch0,
  input  logic [DECIM_W-1:0] decim,
  output logic               pvalid,
  output logic               hsync,
  output logic               vsync,
  output logic               sof,
  output logic [CNT_W-1:0]   width,
  output logic [CNT_W-1:0]   height,
  output logic               meas_valid,
  output logic               stable
);

  localparam logic [9:0] TOK0  = 10'b1101010100;
  localparam logic [9:0] TOK1  = 10'b0010101011;
  localparam logic [9:0] TOK2  = 10'b0101010100;
  localparam logic [9:0] TOK3  = 10'b1010101011;
  localparam logic [9:0] GUARD = 10'b1011001100;

  typedef enum logic [1:0] {
    S_BLANK,
    S_GUARD,
    S_ACTIVE
  } line_state_t;

  line_state_t state_q, state_n;

  logic is_t0, is_t1, is_t2, is_t3, is_tok, is_g;
  logic pv_q, hs_q, vs_q, sof_q;
  logic pv_n, hs_n, vs_n;
  logic vs_rise, vs_fall, pv_rise;
  logic keep_q, arm_q, meas_seen_q;
  logic [DECIM_W-1:0] phase_q;
  logic [CNT_W-1:0]   run_q, lines_q;
  logic [3:0]         gated;

  assign is_t0  = (ch0 == TOK0);
  assign is_t1  = (ch0 == TOK1);
  assign is_t2  = (ch0 == TOK2);
  assign is_t3  = (ch0 == TOK3);
  assign is_tok = is_t0 | is_t1 | is_t2 | is_t3;
  assign is_g   = (ch0 == GUARD);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_BLANK;
    else     state_q <= state_n;
  end

  // A dropped word breaks a guard pair but does not end an active line.
  always_comb begin
    state_n = state_q;
    if (!valid_in) begin
      if (state_q == S_GUARD) state_n = S_BLANK;
    end else if (is_tok) begin
      state_n = S_BLANK;
    end else begin
      unique case (state_q)
        S_BLANK:  if (is_g) state_n = S_GUARD;
        S_GUARD:  state_n = is_g ? S_ACTIVE : S_BLANK;
        S_ACTIVE: state_n = S_ACTIVE;
        default:  state_n = S_BLANK;
      endcase
    end
  end

  always_comb begin
    pv_n = pv_q;
    hs_n = hs_q;
    vs_n = vs_q;
    if (valid_in) begin
      pv_n = (state_q == S_ACTIVE) && !is_tok;
      if (is_tok) begin
        hs_n = is_t1 | is_t3;
        vs_n = is_t2 | is_t3;
      end
    end
  end

  assign vs_rise = vs_n & ~vs_q;
  assign vs_fall = ~vs_n & vs_q;
  assign pv_rise = pv_n & ~pv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      sof_q       <= 1'b0;
      keep_q      <= 1'b0;
      phase_q     <= '1;
      arm_q       <= 1'b0;
      run_q       <= '0;
      lines_q     <= '0;
      width       <= '0;
      height      <= '0;
      meas_valid  <= 1'b0;
      stable      <= 1'b0;
      meas_seen_q <= 1'b0;
    end else begin
      pv_q       <= pv_n;
      hs_q       <= hs_n;
      vs_q       <= vs_n;
      sof_q      <= pv_rise & arm_q & keep_q;
      meas_valid <= vs_rise;

      if (vs_rise) begin
        if (phase_q >= decim) begin
          phase_q <= '0;
          keep_q  <= 1'b1;
        end else begin
          phase_q <= phase_q + 1'b1;
          keep_q  <= 1'b0;
        end
      end

      if (vs_fall)      arm_q <= 1'b1;
      else if (pv_rise) arm_q <= 1'b0;

      if (pv_rise)                   run_q <= CNT_W'(1);
      else if (pv_n && run_q != '1)  run_q <= run_q + 1'b1;

      if (vs_rise)                     lines_q <= '0;
      else if (pv_rise && lines_q != '1) lines_q <= lines_q + 1'b1;

      if (vs_rise) begin
        width       <= run_q;
        height      <= lines_q;
        stable      <= meas_seen_q && (run_q == width) && (lines_q == height);
        meas_seen_q <= 1'b1;
      end
    end
  end

  assign gated = {sof_q, vs_q & keep_q, hs_q & keep_q, pv_q & keep_q};

  if (DELAY == 0) begin : g_nodelay
    assign {sof, vsync, hsync, pvalid} = gated;
  end else begin : g_delay
    logic [3:0] dl [DELAY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DELAY; i++) dl[i] <= '0;
      end else begin
        dl[0] <= gated;
        for (int unsigned i = 1; i < DELAY; i++) dl[i] <= dl[i-1];
      end
    end

    assign {sof, vsync, hsync, pvalid} = dl[DELAY-1];
  end

endmodule
